// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
//
// Single-port byte-wide RAM controller and arbiter between instruction fetch
// (IF) and the MEM stage. One request is accepted at a time and serialised
// into 1..4 byte-wide RAM cycles. 32-bit data is assembled or split
// little-endian. Each requester sees a status (INIT/BUSY/DONE) that it uses to
// raise or drop its stall request.
//
// Optional feature macro: IO_BUFFER_STALL_EN
//   When defined, an extra input io_buffer_full holds off writes to the I/O
//   addresses 0x30000 and 0x30004 while the I/O buffer is full.
//
// Ports:
//   clk            system clock, all state on rising edge
//   rst            asynchronous active-high reset
//   rdy            global enable, low freezes all state
//   io_buffer_full I/O buffer full (only with IO_BUFFER_STALL_EN)
//   if_req         IF requests a 4-byte read
//   if_addr        IF fetch address
//   if_data        fetched word, held until the next IF read completes
//   if_status      IF status: 00 INIT, 01 BUSY, 10 DONE
//   mem_rw         MEM request: 00 none, 01 read, 10 write, 11 none
//   mem_addr       MEM byte address
//   mem_wdata      MEM store data, low bytes used
//   mem_times      MEM byte count 1, 2 or 4 (anything else means 4)
//   mem_rdata      MEM load data, zero-extended, held until next MEM read
//   mem_status     MEM status: 00 INIT, 01 BUSY, 10 DONE
//   ram_din        RAM read byte, valid one cycle after its address
//   ram_dout       RAM write byte
//   ram_a          RAM byte address
//   ram_wr         RAM write strobe (1 = write, 0 = read)
// ---------------------------------------------------------------------------
module mem_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
`ifdef IO_BUFFER_STALL_EN
   input  logic              io_buffer_full,
`endif
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_data,
   output logic [1:0]        if_status,
   input  logic [1:0]        mem_rw,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_wdata,
   input  logic [2:0]        mem_times,
   output logic [31:0]       mem_rdata,
   output logic [1:0]        mem_status,
   input  logic [7:0]        ram_din,
   output logic [7:0]        ram_dout,
   output logic [ADDR_W-1:0] ram_a,
   output logic              ram_wr
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      DONE  = 2'b11
   } state_t;

   localparam logic [1:0] ST_INIT = 2'b00;
   localparam logic [1:0] ST_BUSY = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   state_t            state;
   state_t            state_next;

   logic              serve_mem;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rbuf;
   logic [31:0]       rbuf_next;
   logic [2:0]        n_q;
   logic [2:0]        cnt;
   logic [2:0]        mem_n;
   logic [1:0]        cap_idx;
   logic [1:0]        wr_idx;
   logic              mem_rd_req;
   logic              mem_wr_req;
   logic              read_last;
   logic              write_last;
   logic              stall;

   assign mem_rd_req = (mem_rw == 2'b01);
   assign mem_wr_req = (mem_rw == 2'b10);

   // Byte counts other than 1 and 2 fall back to a full word.
   always_comb begin
      case (mem_times)
         3'd1:    mem_n = 3'd1;
         3'd2:    mem_n = 3'd2;
         default: mem_n = 3'd4;
      endcase
   end

`ifdef IO_BUFFER_STALL_EN
   // ram_a always holds addr+k during WRITE, so it is the address under test.
   assign stall = (state == WRITE) && io_buffer_full &&
                  ((ram_a == ADDR_W'(32'h0003_0000)) ||
                   (ram_a == ADDR_W'(32'h0003_0004)));
`else
   assign stall = 1'b0;
`endif

   // In READ, cnt counts cycles spent in the state. Address k goes out while
   // cnt == k and its byte arrives while cnt == k+1, so the final byte is
   // captured when cnt reaches n.
   assign read_last  = (state == READ) && (cnt == n_q);
   // In WRITE, cnt is the index of the byte currently on the RAM bus.
   assign write_last = (state == WRITE) && !stall && ((cnt + 3'd1) == n_q);

   // cnt is 1..4 whenever a byte is captured; 4 wraps to lane 3.
   assign cap_idx = cnt[1:0] - 2'd1;
   assign wr_idx  = cnt[1:0] + 2'd1;

   // Merge the byte arriving this cycle into the assembly buffer.
   always_comb begin
      rbuf_next = rbuf;
      rbuf_next[{cap_idx, 3'b000} +: 8] = ram_din;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; MEM wins arbitration over IF.
   always_comb begin
      state_next = state;
      if (rdy) begin
         case (state)
            IDLE: begin
               if (mem_rd_req) begin
                  state_next = READ;
               end else if (mem_wr_req) begin
                  state_next = WRITE;
               end else if (if_req) begin
                  state_next = READ;
               end
            end
            READ: begin
               if (read_last) begin
                  state_next = DONE;
               end
            end
            WRITE: begin
               if (write_last) begin
                  state_next = DONE;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // Datapath: request latching, RAM address/data sequencing, byte assembly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         serve_mem <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rbuf      <= '0;
         n_q       <= '0;
         cnt       <= '0;
         ram_a     <= '0;
         ram_dout  <= '0;
         if_data   <= '0;
         mem_rdata <= '0;
      end else if (rdy) begin
         case (state)
            IDLE: begin
               if (mem_rd_req || mem_wr_req) begin
                  serve_mem <= 1'b1;
                  addr_q    <= mem_addr;
                  wdata_q   <= mem_wdata;
                  n_q       <= mem_n;
                  ram_a     <= mem_addr;
                  ram_dout  <= mem_wdata[7:0];
                  cnt       <= '0;
                  rbuf      <= '0;
               end else if (if_req) begin
                  serve_mem <= 1'b0;
                  addr_q    <= if_addr;
                  n_q       <= 3'd4;
                  ram_a     <= if_addr;
                  cnt       <= '0;
                  rbuf      <= '0;
               end
            end
            READ: begin
               cnt <= cnt + 3'd1;
               if (cnt != 3'd0) begin
                  rbuf <= rbuf_next;
               end
               if ((cnt + 3'd1) < n_q) begin
                  ram_a <= addr_q + ADDR_W'(cnt) + ADDR_W'(1);
               end
               if (read_last) begin
                  if (serve_mem) begin
                     mem_rdata <= rbuf_next;
                  end else begin
                     if_data <= rbuf_next;
                  end
               end
            end
            WRITE: begin
               if (!stall && !write_last) begin
                  cnt      <= cnt + 3'd1;
                  ram_a    <= addr_q + ADDR_W'(cnt) + ADDR_W'(1);
                  ram_dout <= wdata_q[{wr_idx, 3'b000} +: 8];
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Status and write-strobe decode from the current state.
   always_comb begin
      if_status  = ST_INIT;
      mem_status = ST_INIT;
      ram_wr     = 1'b0;
      case (state)
         READ, WRITE: begin
            if (serve_mem) begin
               mem_status = ST_BUSY;
            end else begin
               if_status = ST_BUSY;
            end
            ram_wr = (state == WRITE) && !stall;
         end
         DONE: begin
            if (serve_mem) begin
               mem_status = ST_DONE;
            end else begin
               if_status = ST_DONE;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl
//
// Directed self-checking bench for mem_ctrl. A byte RAM model (64 KiB, indexed
// by the low 16 address bits) returns the addressed byte one cycle later and
// shares the global rdy enable with the controller. Cycle 0 of each scenario
// is the cycle in which the request is first presented; outputs are sampled
// 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_mem_ctrl;

   localparam logic [1:0] S_INIT = 2'b00;
   localparam logic [1:0] S_BUSY = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_data;
   logic [1:0]  if_status;
   logic [1:0]  mem_rw;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_times;
   logic [31:0] mem_rdata;
   logic [1:0]  mem_status;
   logic [7:0]  ram_din = 8'h00;
   logic [7:0]  ram_dout;
   logic [31:0] ram_a;
   logic        ram_wr;
`ifdef IO_BUFFER_STALL_EN
   logic        io_buffer_full;
`endif

   logic [7:0]  ram_mem [0:65535];

   int checks = 0;
   int errors = 0;

   mem_ctrl #(.ADDR_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
`ifdef IO_BUFFER_STALL_EN
      .io_buffer_full (io_buffer_full),
`endif
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_data    (if_data),
      .if_status  (if_status),
      .mem_rw     (mem_rw),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_times  (mem_times),
      .mem_rdata  (mem_rdata),
      .mem_status (mem_status),
      .ram_din    (ram_din),
      .ram_dout   (ram_dout),
      .ram_a      (ram_a),
      .ram_wr     (ram_wr)
   );

   always #5 clk = ~clk;

   // RAM model: synchronous read, write on strobe, both gated by rdy.
   always @(posedge clk) begin
      if (rdy) begin
         ram_din <= ram_mem[ram_a[15:0]];
         if (ram_wr) begin
            ram_mem[ram_a[15:0]] = ram_dout;
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
      checks++; if (if_status !== S_INIT) begin errors++; $display("[TB] FAIL reset_if_status got %h expected %h", if_status, S_INIT); end
      checks++; if (mem_status !== S_INIT) begin errors++; $display("[TB] FAIL reset_mem_status got %h expected %h", mem_status, S_INIT); end
      checks++; if (ram_a !== 32'h0) begin errors++; $display("[TB] FAIL reset_ram_a got %h expected 0", ram_a); end
      checks++; if (ram_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_wr got %b expected 0", ram_wr); end
      checks++; if (if_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_if_data got %h expected 0", if_data); end
      checks++; if (mem_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_rdata got %h expected 0", mem_rdata); end
   endtask

   task automatic test_if_fetch;
      logic [31:0] exp_a;
      ram_mem[16'h0100] = 8'h13;
      ram_mem[16'h0101] = 8'h05;
      ram_mem[16'h0102] = 8'h00;
      ram_mem[16'h0103] = 8'h00;
      if_req  = 1'b1;
      if_addr = 32'h0000_0100;
      for (int c = 1; c <= 6; c++) begin
         tick;
         checks++; if (if_status !== ((c == 6) ? S_DONE : S_BUSY)) begin errors++; $display("[TB] FAIL if_fetch_status c=%0d got %h", c, if_status); end
         checks++; if (mem_status !== S_INIT) begin errors++; $display("[TB] FAIL if_fetch_mem_status c=%0d got %h expected 0", c, mem_status); end
         checks++; if (ram_wr !== 1'b0) begin errors++; $display("[TB] FAIL if_fetch_ram_wr c=%0d got %b expected 0", c, ram_wr); end
         if (c <= 4) begin
            exp_a = 32'h0000_0100 + 32'(c - 1);
            checks++; if (ram_a !== exp_a) begin errors++; $display("[TB] FAIL if_fetch_ram_a c=%0d got %h expected %h", c, ram_a, exp_a); end
         end
         if (c == 6) begin
            checks++; if (if_data !== 32'h0000_0513) begin errors++; $display("[TB] FAIL if_fetch_data got %h expected 00000513", if_data); end
            if_req = 1'b0;
         end
      end
      tick;
      checks++; if (if_status !== S_INIT) begin errors++; $display("[TB] FAIL if_fetch_idle got %h expected 0", if_status); end
   endtask

   task automatic test_mem_write;
      ram_mem[16'h2002] = 8'h5A;
      mem_rw    = 2'b10;
      mem_addr  = 32'h0000_2000;
      mem_times = 3'd2;
      mem_wdata = 32'hAABB_CCDD;
      for (int c = 1; c <= 3; c++) begin
         tick;
         checks++; if (mem_status !== ((c == 3) ? S_DONE : S_BUSY)) begin errors++; $display("[TB] FAIL write_status c=%0d got %h", c, mem_status); end
         checks++; if (if_status !== S_INIT) begin errors++; $display("[TB] FAIL write_if_status c=%0d got %h expected 0", c, if_status); end
         checks++; if (ram_wr !== (c != 3)) begin errors++; $display("[TB] FAIL write_ram_wr c=%0d got %b", c, ram_wr); end
         if (c == 1) begin
            checks++; if ({ram_a, ram_dout} !== {32'h0000_2000, 8'hDD}) begin errors++; $display("[TB] FAIL write_byte0 got %h/%h expected 00002000/dd", ram_a, ram_dout); end
         end
         if (c == 2) begin
            checks++; if ({ram_a, ram_dout} !== {32'h0000_2001, 8'hCC}) begin errors++; $display("[TB] FAIL write_byte1 got %h/%h expected 00002001/cc", ram_a, ram_dout); end
         end
         if (c == 3) mem_rw = 2'b00;
      end
      tick;
      checks++; if (mem_status !== S_INIT) begin errors++; $display("[TB] FAIL write_idle got %h expected 0", mem_status); end
      checks++; if ({ram_mem[16'h2000], ram_mem[16'h2001], ram_mem[16'h2002]} !== 24'hDDCC5A) begin
         errors++; $display("[TB] FAIL write_ram_contents got %h%h%h expected ddcc5a", ram_mem[16'h2000], ram_mem[16'h2001], ram_mem[16'h2002]);
      end
   endtask

   task automatic test_arbitration;
      ram_mem[16'h0040] = 8'h80;
      ram_mem[16'h0104] = 8'h93;
      ram_mem[16'h0105] = 8'h00;
      ram_mem[16'h0106] = 8'h10;
      ram_mem[16'h0107] = 8'h00;
      if_req    = 1'b1;
      if_addr   = 32'h0000_0104;
      mem_rw    = 2'b01;
      mem_addr  = 32'h0000_0040;
      mem_times = 3'd1;
      for (int c = 1; c <= 10; c++) begin
         tick;
         if (c <= 3) begin
            checks++; if (mem_status !== ((c == 3) ? S_DONE : S_BUSY)) begin errors++; $display("[TB] FAIL arb_mem_status c=%0d got %h", c, mem_status); end
            checks++; if (if_status !== S_INIT) begin errors++; $display("[TB] FAIL arb_if_wait c=%0d got %h expected 0", c, if_status); end
         end else begin
            checks++; if (mem_status !== S_INIT) begin errors++; $display("[TB] FAIL arb_mem_after c=%0d got %h expected 0", c, mem_status); end
            checks++; if (if_status !== ((c == 4) ? S_INIT : ((c == 10) ? S_DONE : S_BUSY))) begin errors++; $display("[TB] FAIL arb_if_status c=%0d got %h", c, if_status); end
         end
         if (c == 1) begin
            checks++; if (ram_a !== 32'h0000_0040) begin errors++; $display("[TB] FAIL arb_mem_addr got %h expected 00000040", ram_a); end
         end
         if (c == 3) begin
            checks++; if (mem_rdata !== 32'h0000_0080) begin errors++; $display("[TB] FAIL arb_mem_rdata got %h expected 00000080", mem_rdata); end
            mem_rw = 2'b00;
         end
         if (c == 5) begin
            checks++; if (ram_a !== 32'h0000_0104) begin errors++; $display("[TB] FAIL arb_if_addr got %h expected 00000104", ram_a); end
         end
         if (c == 10) begin
            checks++; if (if_data !== 32'h0010_0093) begin errors++; $display("[TB] FAIL arb_if_data got %h expected 00100093", if_data); end
            if_req = 1'b0;
         end
      end
      tick;
      checks++; if (if_status !== S_INIT) begin errors++; $display("[TB] FAIL arb_idle got %h expected 0", if_status); end
      checks++; if (mem_rdata !== 32'h0000_0080) begin errors++; $display("[TB] FAIL arb_mem_rdata_hold got %h expected 00000080", mem_rdata); end
   endtask

   task automatic test_wrap_and_times;
      logic [31:0] seq [4];
      seq[0] = 32'hFFFF_FFFE;
      seq[1] = 32'hFFFF_FFFF;
      seq[2] = 32'h0000_0000;
      seq[3] = 32'h0000_0001;
      ram_mem[16'hFFFE] = 8'h11;
      ram_mem[16'hFFFF] = 8'h22;
      ram_mem[16'h0000] = 8'h33;
      ram_mem[16'h0001] = 8'h44;
      if_req  = 1'b1;
      if_addr = 32'hFFFF_FFFE;
      for (int c = 1; c <= 6; c++) begin
         tick;
         if (c <= 4) begin
            checks++; if (ram_a !== seq[c-1]) begin errors++; $display("[TB] FAIL wrap_ram_a c=%0d got %h expected %h", c, ram_a, seq[c-1]); end
         end
         if (c == 6) begin
            checks++; if (if_status !== S_DONE) begin errors++; $display("[TB] FAIL wrap_done got %h expected 2", if_status); end
            checks++; if (if_data !== 32'h4433_2211) begin errors++; $display("[TB] FAIL wrap_data got %h expected 44332211", if_data); end
            if_req = 1'b0;
         end
      end
      tick;
      // mem_times of 3 means a full word.
      mem_rw    = 2'b01;
      mem_addr  = 32'h0000_0100;
      mem_times = 3'd3;
      for (int c = 1; c <= 6; c++) begin
         tick;
         checks++; if (mem_status !== ((c == 6) ? S_DONE : S_BUSY)) begin errors++; $display("[TB] FAIL times3_status c=%0d got %h", c, mem_status); end
         if (c == 6) begin
            checks++; if (mem_rdata !== 32'h0000_0513) begin errors++; $display("[TB] FAIL times3_data got %h expected 00000513", mem_rdata); end
            mem_rw = 2'b00;
         end
      end
      tick;
   endtask

   task automatic test_reset_mid_write;
      ram_mem[16'h3000] = 8'h00;
      ram_mem[16'h3001] = 8'h00;
      ram_mem[16'h3002] = 8'h00;
      ram_mem[16'h3003] = 8'h00;
      mem_rw    = 2'b10;
      mem_addr  = 32'h0000_3000;
      mem_times = 3'd4;
      mem_wdata = 32'h1122_3344;
      tick;
      tick;
      tick;
      checks++; if (ram_a !== 32'h0000_3002) begin errors++; $display("[TB] FAIL abort_pre_addr got %h expected 00003002", ram_a); end
      rst = 1'b1;
      #1;
      checks++; if ({ram_a, ram_dout, ram_wr} !== 41'h0) begin errors++; $display("[TB] FAIL abort_outputs got %h/%h/%b expected 0", ram_a, ram_dout, ram_wr); end
      checks++; if ({mem_status, if_status} !== 4'h0) begin errors++; $display("[TB] FAIL abort_status got %h/%h expected 0", mem_status, if_status); end
      rst    = 1'b0;
      mem_rw = 2'b00;
      for (int c = 1; c <= 3; c++) begin
         tick;
         checks++; if (mem_status !== S_INIT) begin errors++; $display("[TB] FAIL abort_no_done c=%0d got %h expected 0", c, mem_status); end
      end
      checks++; if ({ram_mem[16'h3000], ram_mem[16'h3001], ram_mem[16'h3002], ram_mem[16'h3003]} !== 32'h4433_0000) begin
         errors++; $display("[TB] FAIL abort_ram got %h%h%h%h expected 44330000", ram_mem[16'h3000], ram_mem[16'h3001], ram_mem[16'h3002], ram_mem[16'h3003]);
      end
      mem_rw    = 2'b01;
      mem_times = 3'd2;
      for (int c = 1; c <= 4; c++) begin
         tick;
         checks++; if (mem_status !== ((c == 4) ? S_DONE : S_BUSY)) begin errors++; $display("[TB] FAIL abort_next_status c=%0d got %h", c, mem_status); end
         if (c == 4) begin
            checks++; if (mem_rdata !== 32'h0000_3344) begin errors++; $display("[TB] FAIL abort_next_data got %h expected 00003344", mem_rdata); end
            mem_rw = 2'b00;
         end
      end
      tick;
   endtask

   task automatic test_rdy_freeze;
      logic [31:0] exp_a;
      if_req  = 1'b1;
      if_addr = 32'h0000_0100;
      for (int c = 1; c <= 9; c++) begin
         tick;
         if (c == 3) rdy = 1'b0;
         if (c == 6) rdy = 1'b1;
         checks++; if (if_status !== ((c == 9) ? S_DONE : S_BUSY)) begin errors++; $display("[TB] FAIL rdy_status c=%0d got %h", c, if_status); end
         if (c <= 7) begin
            exp_a = (c <= 2) ? 32'h0000_0100 + 32'(c - 1) : ((c <= 6) ? 32'h0000_0102 : 32'h0000_0103);
            checks++; if (ram_a !== exp_a) begin errors++; $display("[TB] FAIL rdy_ram_a c=%0d got %h expected %h", c, ram_a, exp_a); end
         end
         if (c == 9) begin
            checks++; if (if_data !== 32'h0000_0513) begin errors++; $display("[TB] FAIL rdy_data got %h expected 00000513", if_data); end
            if_req = 1'b0;
         end
      end
      tick;
      checks++; if (if_status !== S_INIT) begin errors++; $display("[TB] FAIL rdy_idle got %h expected 0", if_status); end
   endtask

`ifdef IO_BUFFER_STALL_EN
   task automatic test_io_stall;
      ram_mem[16'h0000] = 8'h00;
      io_buffer_full = 1'b1;
      mem_rw    = 2'b10;
      mem_addr  = 32'h0003_0000;
      mem_times = 3'd1;
      mem_wdata = 32'h0000_00A5;
      for (int c = 1; c <= 6; c++) begin
         tick;
         if (c == 5) io_buffer_full = 1'b0;
         checks++; if (mem_status !== ((c == 6) ? S_DONE : S_BUSY)) begin errors++; $display("[TB] FAIL stall_status c=%0d got %h", c, mem_status); end
         checks++; if (ram_wr !== (c == 5)) begin errors++; $display("[TB] FAIL stall_ram_wr c=%0d got %b", c, ram_wr); end
         if (c <= 5) begin
            checks++; if (ram_a !== 32'h0003_0000) begin errors++; $display("[TB] FAIL stall_ram_a c=%0d got %h expected 00030000", c, ram_a); end
         end
         if (c == 6) mem_rw = 2'b00;
      end
      tick;
      checks++; if (ram_mem[16'h0000] !== 8'hA5) begin errors++; $display("[TB] FAIL stall_ram got %h expected a5", ram_mem[16'h0000]); end
   endtask
`endif

   initial begin
      for (int i = 0; i < 65536; i++) ram_mem[i] = 8'h00;
      rst       = 1'b0;
      rdy       = 1'b1;
      if_req    = 1'b0;
      if_addr   = 32'h0;
      mem_rw    = 2'b00;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      mem_times = 3'd0;
`ifdef IO_BUFFER_STALL_EN
      io_buffer_full = 1'b0;
`endif
      #1;
      test_reset;
      test_if_fetch;
      test_mem_write;
      test_arbitration;
      test_wrap_and_times;
      test_reset_mid_write;
      test_rdy_freeze;
`ifdef IO_BUFFER_STALL_EN
      test_io_stall;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port byte-wide RAM controller and arbiter between instruction fetch (IF) and the MEM stage.
- Accepts one word-fetch or load/store request at a time and serialises it into 1..4 byte RAM cycles.
- Assembles or splits 32-bit data little-endian and reports per-requester status (INIT/BUSY/DONE), which the stages use to raise or drop their stall requests.

Parameters:
- ADDR_W, 32, address width of requesters and RAM.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global enable; low freezes all state.
- if_req  in  1  IF requests a 4-byte read.
- if_addr  in  32  IF fetch address.
- if_data  out  32  fetched word.
- if_status  out  2  IF status.
- mem_rw  in  2  MEM request: 00 none, 01 read, 10 write, 11 treated as none.
- mem_addr  in  32  MEM byte address.
- mem_wdata  in  32  store data, low bytes used.
- mem_times  in  3  byte count 1, 2 or 4.
- mem_rdata  out  32  load data, zero-extended (MEM stage sign-extends).
- mem_status  out  2  MEM status.
- ram_din  in  8  RAM read byte, valid one cycle after its address.
- ram_dout  out  8  RAM write byte.
- ram_a  out  32  RAM byte address.
- ram_wr  out  1  1 = write, 0 = read.

Behaviour:
- Status encoding: 00 INIT (no transaction), 01 BUSY, 10 DONE.
- Reset (async, any state, including mid-transaction): state IDLE, counters 0, all outputs 0. The aborted transaction is dropped, with no DONE.
- rdy=0: registers hold; no counter advance.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE, arbitration: MEM beats IF when both request in the same cycle. MEM read goes to READ and MEM write goes to WRITE, with n=mem_times. Otherwise if_req goes to READ with n=4. Requester address, data and n are latched at acceptance.
- mem_times of 0, 3 or >4 is treated as 4.
- Transactions are non-preemptible. Requests arriving while busy wait and are not queued.
- READ, registered outputs: ram_a=addr+k for k=0..n-1 on consecutive cycles, ram_wr=0.
  - Byte k is captured into rdata[8k+7:8k] one cycle after ram_a=addr+k.
  - Bytes k>=n read as 0.
  - After byte n-1 is captured, go to DONE.
  - Request at cycle 0 gives DONE in cycle n+2.
- WRITE: ram_a=addr+k, ram_dout=wdata[8k+7:8k], ram_wr=1 for k=0..n-1 on consecutive cycles, then DONE. Request at cycle 0 gives DONE in cycle n+1.
- Status outputs:
  - While in READ or WRITE, the served requester's status is BUSY and the other requester's is INIT.
  - DONE lasts exactly one cycle, with if_data or mem_rdata valid in that cycle.
  - ram_wr=0 in DONE.
  - The cycle after DONE the FSM is in IDLE and statuses are INIT.
- Requesters must deassert their request in the DONE cycle. A request still asserted in IDLE starts a new transaction.
- if_data and mem_rdata hold their last values until that port's next read completes.
- Address increment wraps modulo 2^32.
- ram_wr is 0 in every state except WRITE.

Optional Feature:
- Macro IO_BUFFER_STALL_EN.
- When defined:
  - Extra input port io_buffer_full (1 bit).
  - In WRITE, when addr+k is 0x30000 or 0x30004 and io_buffer_full=1, ram_wr is driven 0, k does not advance, and status stays BUSY.
  - The write resumes the cycle after io_buffer_full falls.
- When undefined: the port is absent and writes are never stalled.

Test Plan:
1. Reset, then if_req=1, if_addr=0x100 with RAM[0x100..0x103]=13,05,00,00 -> ram_a 0x100..0x103, if_status BUSY, DONE in cycle 6, if_data=0x00000513, mem_status INIT throughout.
2. mem_rw=10, mem_addr=0x2000, mem_times=2, mem_wdata=0xAABBCCDD -> ram_wr=1 with (0x2000,DD) then (0x2001,CC), mem_status DONE in cycle 3, RAM[0x2002] unchanged.
3. if_req=1 and mem_rw=01 (addr 0x40, times=1, RAM[0x40]=0x80) asserted in the same cycle -> MEM served first with mem_rdata=0x00000080 and if_status INIT meanwhile; IF served after DONE and returns to IDLE.
4. 4-byte read at 0xFFFFFFFE -> ram_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
5. rst pulsed mid-WRITE after 2 bytes of 4 -> outputs immediately 0, no DONE issued, next request is served normally.
6. rdy=0 for 3 cycles during a READ -> ram_a and counters frozen; data is still correct and DONE is delayed by exactly 3 cycles.
   - With IO_BUFFER_STALL_EN: write to 0x30000 with io_buffer_full=1 for 4 cycles -> ram_wr is held 0 for 4 cycles, then the byte is written.
